// File: rtl/time_set_ctrl_pkg.sv
// rtl/time_set_ctrl_pkg.sv - shared field widths, limits, state encoding and time packing
// Purpose: common definitions for the time-setting front end and its field steppers.
// Ports: none (package).
package time_set_ctrl_pkg;

   localparam int H_W      = 5;
   localparam int M_W      = 6;
   localparam int S_W      = 6;
   localparam int T_W      = H_W + M_W + S_W;
   localparam int HOUR_MAX = 23;
   localparam int MS_MAX   = 59;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SET_H  = 3'd1,
      SET_M  = 3'd2,
      SET_S  = 3'd3,
      COMMIT = 3'd4
   } state_t;

   // Same bit layout as the clock's time bus: {hour, min, sec}.
   typedef struct packed {
      logic [H_W-1:0] hour;
      logic [M_W-1:0] min;
      logic [S_W-1:0] sec;
   } time_t;

endpackage

// File: rtl/time_set_ctrl_field_stepper.sv
// rtl/time_set_ctrl_field_stepper.sv - combinational +/-1 with wrap for one time field
// Purpose: computes the stepped value of a single hour/min/sec field.
// Ports:
//   val  in  W  current field value
//   inc  in  1  request +1
//   dec  in  1  request -1
//   next out W  stepped value (equals val when no step or both requests)
module field_stepper #(
   parameter int W   = 6,
   parameter int MAX = 59
) (
   input  logic [W-1:0] val,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] next
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   // An out-of-range value (possible when loaded from the running time)
   // snaps to zero on the first step in either direction.
   always_comb begin
      next = val;
      if (inc && !dec) begin
         next = (val >= MAX_V) ? '0 : val + 1'b1;
      end else if (dec && !inc) begin
         if (val > MAX_V)
            next = '0;
         else if (val == '0)
            next = MAX_V;
         else
            next = val - 1'b1;
      end
   end

endmodule

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - button-driven time editor that commits through the overwrite interface
// Purpose: edits a copy of the running time field by field and requests an overwrite on commit.
// Ports:
//   clk       in  1   system clock
//   rst       in  1   synchronous active-high reset
//   btn_mode  in  1   pulse: enter edit / next field / commit
//   btn_inc   in  1   pulse: +1 active field
//   btn_dec   in  1   pulse: -1 active field
//   time_cur  in  17  running time {hour,min,sec}
//   time_set  out 17  edited time, same packing
//   time_ow   out 1   overwrite request, held OW_HOLD cycles
//   field_sel out 3   one-hot {hour,min,sec} being edited
//   busy      out 1   not idle
module time_set_ctrl
   import time_set_ctrl_pkg::*;
#(
   parameter int unsigned OW_HOLD = 100_000_001,
   parameter int unsigned TIMEOUT = 1_000_000_000
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           btn_mode,
   input  logic           btn_inc,
   input  logic           btn_dec,
   input  logic [T_W-1:0] time_cur,
   output logic [T_W-1:0] time_set,
   output logic           time_ow,
   output logic [2:0]     field_sel,
   output logic           busy
);

   localparam int HOLD_W = $clog2(OW_HOLD + 1);
   localparam int IDLE_W = $clog2(TIMEOUT + 1);

   state_t            state, state_next;
   time_t             edit, cur, stepped;
   logic [HOLD_W-1:0] hold_cnt;
   logic [IDLE_W-1:0] idle_cnt;
   logic              editing, any_btn, hold_done, timed_out, step_ok;

   assign cur       = time_cur;
   assign time_set  = edit;
   assign editing   = (state == SET_H) || (state == SET_M) || (state == SET_S);
   assign any_btn   = btn_mode || btn_inc || btn_dec;
   assign hold_done = (hold_cnt == HOLD_W'(OW_HOLD - 1));
   assign timed_out = editing && !any_btn && (idle_cnt == IDLE_W'(TIMEOUT - 1));
   // btn_mode wins: a step arriving with it is dropped.
   assign step_ok   = !btn_mode;

   field_stepper #(.W(H_W), .MAX(HOUR_MAX)) u_hour (
      .val  (edit.hour),
      .inc  (btn_inc && step_ok && state == SET_H),
      .dec  (btn_dec && step_ok && state == SET_H),
      .next (stepped.hour)
   );

   field_stepper #(.W(M_W), .MAX(MS_MAX)) u_min (
      .val  (edit.min),
      .inc  (btn_inc && step_ok && state == SET_M),
      .dec  (btn_dec && step_ok && state == SET_M),
      .next (stepped.min)
   );

   field_stepper #(.W(S_W), .MAX(MS_MAX)) u_sec (
      .val  (edit.sec),
      .inc  (btn_inc && step_ok && state == SET_S),
      .dec  (btn_dec && step_ok && state == SET_S),
      .next (stepped.sec)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (btn_mode) state_next = SET_H;
         SET_H:   if (btn_mode) state_next = SET_M;
                  else if (timed_out) state_next = IDLE;
         SET_M:   if (btn_mode) state_next = SET_S;
                  else if (timed_out) state_next = IDLE;
         SET_S:   if (btn_mode) state_next = COMMIT;
                  else if (timed_out) state_next = IDLE;
         COMMIT:  if (hold_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Decoded from the state register, so time_ow drops on the reset edge.
   always_comb begin
      time_ow   = (state == COMMIT);
      busy      = (state != IDLE);
      field_sel = 3'b000;
      case (state)
         SET_H:   field_sel = 3'b100;
         SET_M:   field_sel = 3'b010;
         SET_S:   field_sel = 3'b001;
         default: field_sel = 3'b000;
      endcase
   end

   // Edit register: time_cur is only sampled on entry to SET_H.
   always_ff @(posedge clk) begin
      if (rst)
         edit <= '0;
      else if (state == IDLE && btn_mode)
         edit <= cur;
      else if (editing)
         edit <= stepped;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt <= '0;
         idle_cnt <= '0;
      end else begin
         hold_cnt <= (state == COMMIT) ? hold_cnt + 1'b1 : '0;
         if (!editing || any_btn || state_next != state)
            idle_cnt <= '0;
         else
            idle_cnt <= idle_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - self-checking bench: vector table, corner sequences, random vs model
module tb_time_set_ctrl;

   localparam int OW_HOLD = 4;
   localparam int TIMEOUT = 20;

   logic        clk = 1'b0;
   logic        rst, btn_mode, btn_inc, btn_dec;
   logic [16:0] time_cur, time_set;
   logic        time_ow, busy;
   logic [2:0]  field_sel;

   int tests = 0;
   int fails = 0;

   time_set_ctrl #(.OW_HOLD(OW_HOLD), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_mode  (btn_mode),
      .btn_inc   (btn_inc),
      .btn_dec   (btn_dec),
      .time_cur  (time_cur),
      .time_set  (time_set),
      .time_ow   (time_ow),
      .field_sel (field_sel),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [16:0] pk(input int h, input int m, input int s);
      logic [4:0] hh;
      logic [5:0] mm, ss;
      hh = h[4:0];
      mm = m[5:0];
      ss = s[5:0];
      return {hh, mm, ss};
   endfunction

   typedef struct {
      logic        rst, mode, inc, dec;
      logic [16:0] cur;
      logic [16:0] e_set;
      logic        e_ow;
      logic [2:0]  e_fs;
      logic        e_busy;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic m, input logic i, input logic d,
                      input logic [16:0] c, input logic [16:0] es, input logic eo,
                      input logic [2:0] ef, input logic eb);
      vec_t v;
      v.rst = r; v.mode = m; v.inc = i; v.dec = d; v.cur = c;
      v.e_set = es; v.e_ow = eo; v.e_fs = ef; v.e_busy = eb;
      vecs.push_back(v);
   endtask

   // Inputs are held across one rising edge; outputs sampled 1 time unit after it.
   task automatic apply(input logic r, input logic m, input logic i, input logic d,
                        input logic [16:0] c);
      rst = r; btn_mode = m; btn_inc = i; btn_dec = d; time_cur = c;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [16:0] es, input logic eo,
                        input logic [2:0] ef, input logic eb);
      tests++;
      if (time_set !== es || time_ow !== eo || field_sel !== ef || busy !== eb) begin
         fails++;
         $display("FAIL %s: got set=%h ow=%b fs=%b busy=%b, want set=%h ow=%b fs=%b busy=%b",
                  name, time_set, time_ow, field_sel, busy, es, eo, ef, eb);
      end
   endtask

   // Reference model: phase 0 idle, 1..3 editing hour/min/sec, 4 committing.
   int m_ph, m_h, m_m, m_s, m_hold, m_idle;

   function automatic int stepf(input int v, input int max, input int d);
      if (v > max) return 0;
      return (v + d + max + 1) % (max + 1);
   endfunction

   task automatic model(input logic r, input logic mo, input logic i, input logic d,
                        input logic [16:0] c);
      int dl;
      dl = (i && !d) ? 1 : (d && !i) ? -1 : 0;
      if (r) begin
         m_ph = 0; m_h = 0; m_m = 0; m_s = 0; m_hold = 0; m_idle = 0;
      end else if (m_ph == 0) begin
         if (mo) begin
            m_h = c[16:12]; m_m = c[11:6]; m_s = c[5:0];
            m_ph = 1; m_idle = 0;
         end
      end else if (m_ph == 4) begin
         m_hold++;
         if (m_hold == OW_HOLD) m_ph = 0;
      end else if (mo) begin
         m_ph++; m_idle = 0; m_hold = 0;
      end else begin
         if (dl != 0) begin
            if (m_ph == 1) m_h = stepf(m_h, 23, dl);
            if (m_ph == 2) m_m = stepf(m_m, 59, dl);
            if (m_ph == 3) m_s = stepf(m_s, 59, dl);
         end
         if (i || d) m_idle = 0;
         else begin
            m_idle++;
            if (m_idle == TIMEOUT) m_ph = 0;
         end
      end
   endtask

   function automatic logic [2:0] m_fs();
      case (m_ph)
         1: return 3'b100;
         2: return 3'b010;
         3: return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   initial begin
      logic [16:0] c1, c2, c3, c4, c5, rc;
      logic        r, mo, i, d;
      c1 = pk(12, 30, 45);
      c2 = pk(23, 0, 59);
      c3 = pk(5, 6, 7);
      c4 = pk(31, 63, 63);

      // Basic set sequence.
      add(1, 0, 0, 0, c1, 17'd0,          0, 3'b000, 0);
      add(0, 1, 0, 0, c1, pk(12, 30, 45), 0, 3'b100, 1);
      add(0, 0, 1, 0, c1, pk(13, 30, 45), 0, 3'b100, 1);
      add(0, 0, 1, 0, c1, pk(14, 30, 45), 0, 3'b100, 1);
      add(0, 1, 0, 0, c1, pk(14, 30, 45), 0, 3'b010, 1);
      add(0, 0, 0, 1, c1, pk(14, 29, 45), 0, 3'b010, 1);
      add(0, 1, 0, 0, c1, pk(14, 29, 45), 0, 3'b001, 1);
      add(0, 1, 0, 0, c1, pk(14, 29, 45), 1, 3'b000, 1);
      add(0, 0, 0, 0, c1, pk(14, 29, 45), 1, 3'b000, 1);
      add(0, 1, 1, 0, c1, pk(14, 29, 45), 1, 3'b000, 1);
      add(0, 0, 0, 1, c1, pk(14, 29, 45), 1, 3'b000, 1);
      add(0, 0, 0, 0, c1, pk(14, 29, 45), 0, 3'b000, 0);
      add(0, 0, 1, 0, c2, pk(14, 29, 45), 0, 3'b000, 0);
      // Wrap at every field, inc+dec, mode+inc priority.
      add(0, 1, 0, 0, c2, pk(23, 0, 59),  0, 3'b100, 1);
      add(0, 0, 1, 0, c2, pk(0, 0, 59),   0, 3'b100, 1);
      add(0, 1, 0, 0, c2, pk(0, 0, 59),   0, 3'b010, 1);
      add(0, 0, 0, 1, c2, pk(0, 59, 59),  0, 3'b010, 1);
      add(0, 1, 0, 0, c2, pk(0, 59, 59),  0, 3'b001, 1);
      add(0, 0, 1, 0, c2, pk(0, 59, 0),   0, 3'b001, 1);
      add(0, 0, 1, 1, c2, pk(0, 59, 0),   0, 3'b001, 1);
      add(0, 1, 1, 0, c2, pk(0, 59, 0),   1, 3'b000, 1);
      add(1, 0, 0, 0, c3, 17'd0,          0, 3'b000, 0);
      add(0, 1, 0, 0, c3, pk(5, 6, 7),    0, 3'b100, 1);
      add(0, 1, 1, 0, c3, pk(5, 6, 7),    0, 3'b010, 1);
      add(0, 1, 0, 1, c3, pk(5, 6, 7),    0, 3'b001, 1);
      add(1, 0, 0, 0, c3, 17'd0,          0, 3'b000, 0);
      // Out-of-range load snaps on first step.
      add(0, 1, 0, 0, c4, pk(31, 63, 63), 0, 3'b100, 1);
      add(0, 0, 0, 1, c4, pk(0, 63, 63),  0, 3'b100, 1);
      add(0, 1, 0, 0, c4, pk(0, 63, 63),  0, 3'b010, 1);
      add(0, 0, 1, 0, c4, pk(0, 0, 63),   0, 3'b010, 1);
      add(0, 1, 0, 0, c4, pk(0, 0, 63),   0, 3'b001, 1);
      add(0, 0, 1, 0, c4, pk(0, 0, 0),    0, 3'b001, 1);

      rst = 1; btn_mode = 0; btn_inc = 0; btn_dec = 0; time_cur = '0;
      @(posedge clk);
      #1;
      foreach (vecs[k]) begin
         apply(vecs[k].rst, vecs[k].mode, vecs[k].inc, vecs[k].dec, vecs[k].cur);
         check($sformatf("vec%0d", k), vecs[k].e_set, vecs[k].e_ow, vecs[k].e_fs, vecs[k].e_busy);
      end

      // Timeout in SET_M: 19 idle cycles stay, the 20th abandons without commit.
      c5 = pk(8, 9, 10);
      apply(1, 0, 0, 0, c5);
      apply(0, 1, 0, 0, c5);
      apply(0, 1, 0, 0, c5);
      check("to_enter", c5, 0, 3'b010, 1);
      for (int n = 1; n <= TIMEOUT; n++) begin
         apply(0, 0, 0, 0, c5);
         if (n < TIMEOUT) check($sformatf("to_wait%0d", n), c5, 0, 3'b010, 1);
         else             check("to_expire", c5, 0, 3'b000, 0);
      end
      apply(0, 0, 0, 0, c5);
      check("to_after", c5, 0, 3'b000, 0);

      // Reset on COMMIT cycle 2, then reload from a new time_cur.
      apply(0, 1, 0, 0, c5);
      apply(0, 1, 0, 0, c5);
      apply(0, 1, 0, 0, c5);
      apply(0, 1, 0, 0, c5);
      check("cm_cycle1", c5, 1, 3'b000, 1);
      apply(0, 0, 0, 0, c5);
      check("cm_cycle2", c5, 1, 3'b000, 1);
      apply(1, 0, 0, 0, c5);
      check("cm_reset", 17'd0, 0, 3'b000, 0);
      apply(0, 1, 0, 0, c3);
      check("cm_reload", c3, 0, 3'b100, 1);

      // Random traffic against the model.
      apply(1, 0, 0, 0, '0);
      model(1, 0, 0, 0, '0);
      for (int n = 0; n < 4000; n++) begin
         r  = ($urandom_range(0, 299) == 0);
         mo = ($urandom_range(0, 7) == 0);
         i  = ($urandom_range(0, 4) == 0);
         d  = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 3) == 0) begin
            mo = 0; i = 0; d = 0;
         end
         if ((n / 500) % 2 == 1) begin
            i = i && ($urandom_range(0, 5) == 0);
            d = d && ($urandom_range(0, 5) == 0);
         end
         if ($urandom_range(0, 9) == 0)
            rc = 17'($urandom);
         else
            rc = pk($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
         apply(r, mo, i, d, rc);
         model(r, mo, i, d, rc);
         check($sformatf("rnd%0d", n), pk(m_h, m_m, m_s), m_ph == 4, m_fs(), m_ph != 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
